grid_sweep_reader: RTL

Read-side client for the 2500-word single-port grid RAMs (50×50 lattice, 1-cycle read latency). On a `start` pulse it sweeps addresses 0..DEPTH-1 in raster order and presents each word on a valid/ready stream tagged with row/column coordinates. It absorbs downstream backpressure through a 2-entry buffer and sustains one word per cycle when `m_ready` is held high. It sits between a grid RAM and the collision/streaming compute pipeline.

---
 rtl/grid_sweep_reader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/grid_sweep_reader.sv
// Raster-order reader for a 1-cycle-latency grid RAM. Each word is presented
// on a valid/ready stream with its row/col, buffered two deep against stalls.
module grid_sweep_reader #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = 2500,
    parameter int GRID_W        = 50,
    parameter int COORD_WIDTH   = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_write_en,
    input  logic [DATA_WIDTH-1:0]    ram_data,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [COORD_WIDTH-1:0]   m_row,
    output logic [COORD_WIDTH-1:0]   m_col
);
    localparam int                     ISS_WIDTH = $clog2(DEPTH + 1);
    localparam logic [ISS_WIDTH-1:0]   ISS_END   = ISS_WIDTH'(DEPTH);
    localparam logic [COORD_WIDTH-1:0] LAST_ROW  = COORD_WIDTH'(DEPTH / GRID_W - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_COL  = COORD_WIDTH'(GRID_W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ISS_WIDTH-1:0]     iss;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     inflight;
    logic [1:0]               occ;
    logic [DATA_WIDTH-1:0]    buf_head;
    logic [DATA_WIDTH-1:0]    buf_tail;
    logic [COORD_WIDTH-1:0]   row;
    logic [COORD_WIDTH-1:0]   col;
    logic                     issue;
    logic                     pop;
    logic [2:0]               pending;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next = state;
        issue      = 1'b0;
        pop        = m_valid & m_ready;
        // Words that will occupy the buffer after this edge; pop never exceeds occ.
        pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                issue = (iss < ISS_END) && (pending < 3'd2);
                if (pop && m_last) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign ram_addr     = issue ? ADDRESS_WIDTH'(iss) : addr_q;
    assign ram_write_en = 1'b0;
    assign m_valid      = (occ != 2'd0);
    assign m_data       = buf_head;
    assign m_row        = row;
    assign m_col        = col;
    assign m_last       = (row == LAST_ROW) && (col == LAST_COL) && m_valid;

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
        if (!rst_n) begin
            state    <= ST_IDLE;
            iss      <= '0;
            addr_q   <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            // NOTE: the two buffer words are plain flops, reset so m_data reads 0 out of reset.
            buf_head <= '0;
            buf_tail <= '0;
            row      <= '0;
            col      <= '0;
        end else begin
            state    <= state_next;
            inflight <= issue;

            if (issue) begin
                iss    <= iss + 1'b1;
                addr_q <= ram_addr;
            end

            if (state == ST_IDLE && start) begin
                iss <= '0;
                row <= '0;
                col <= '0;
            end else if (pop) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            // The word read last cycle lands behind whatever survives this pop.
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) buf_head <= ram_data;
                    else             buf_tail <= ram_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf_head <= ram_data;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= ram_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
